// File: rtl/traffic_phase_ctrl_pkg.sv
// Shared types and helpers for the traffic phase sequencer.
// Latency: none (types, constants and pure functions only).
// Backpressure: n/a.
// Contents: phase_e / sub_e state enums, lamp encodings {R,Y,G},
//           per-phase timer-select lookup, lamp lookups, phase successor.
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_G,
        NS_Y,
        RED1,
        EW_G,
        EW_Y,
        RED2,
        FAULT
    } phase_e;

    typedef enum logic {
        GAP,
        RUN
    } sub_e;

    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_GRN = 3'b001;

    typedef struct packed {
        logic long_sel;
        logic short_sel;
    } tsel_t;

    // Timer select used while a phase is in RUN. Greens run the long timer,
    // every other timed phase the short one; FAULT runs no timer at all.
    function automatic tsel_t phase_tsel(input phase_e p);
        tsel_t t;
        t = '0;
        case (p)
            NS_G, EW_G:             t.long_sel  = 1'b1;
            NS_Y, RED1, EW_Y, RED2: t.short_sel = 1'b1;
            default:                t = '0;
        endcase
        return t;
    endfunction

    function automatic logic [2:0] ns_lamp(input phase_e p);
        logic [2:0] l;
        case (p)
            NS_G:    l = L_GRN;
            NS_Y:    l = L_YEL;
            default: l = L_RED;
        endcase
        return l;
    endfunction

    function automatic logic [2:0] ew_lamp(input phase_e p);
        logic [2:0] l;
        case (p)
            EW_G:    l = L_GRN;
            EW_Y:    l = L_YEL;
            default: l = L_RED;
        endcase
        return l;
    endfunction

    // Fixed ring order; NS green extension is decided by the caller.
    function automatic phase_e phase_succ(input phase_e p);
        phase_e n;
        case (p)
            NS_G:    n = NS_Y;
            NS_Y:    n = RED1;
            RED1:    n = EW_G;
            EW_G:    n = EW_Y;
            EW_Y:    n = RED2;
            RED2:    n = NS_G;
            default: n = FAULT;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/traffic_phase_ctrl_watchdog.sv
// Phase watchdog: counts RUN cycles, flags when a phase overstays its limit.
// Latency: expired is combinational from the count; it is high in the
//          WDOG_LIMIT-th consecutive enabled cycle. Backpressure: none.
// Ports: clk, rst (sync, active-high), clr (restart count), en (count this
//        cycle), expired (limit reached in the current enabled cycle).
module phase_watchdog #(
    parameter int WDOG_LIMIT = 200,
    // 2**WDOG_W must exceed WDOG_LIMIT so the terminal value is representable.
    parameter int WDOG_W     = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [WDOG_W-1:0] LAST = WDOG_W'(WDOG_LIMIT - 1);

    logic [WDOG_W-1:0] cnt;

    // cnt holds the number of enabled cycles already completed, so the
    // current cycle is the last allowed one when cnt reaches LAST.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && (cnt != LAST)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = en && (cnt == LAST);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Traffic phase sequencer driving the downstream counter's timer selects.
// Latency: all outputs registered, one cycle after the deciding input.
// Backpressure: none; paced only by i_done_counter from the counter.
// Ports: clk, rst (sync, active-high); i_done_counter / i_almost_done from
//        the counter; i_ew_sensor / i_ped_req demand inputs;
//        o_short_counter / o_long_counter timer selects; o_ns_light /
//        o_ew_light one-hot {R,Y,G}; o_walk, o_walk_flash, o_fault (sticky).
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int WDOG_LIMIT = 200,
    parameter int WDOG_W     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_done_counter,
    input  logic       i_almost_done,
    input  logic       i_ew_sensor,
    input  logic       i_ped_req,
    output logic       o_short_counter,
    output logic       o_long_counter,
    output logic [2:0] o_ns_light,
    output logic [2:0] o_ew_light,
    output logic       o_walk,
    output logic       o_walk_flash,
    output logic       o_fault
);

    phase_e phase;
    phase_e nxt_phase;
    sub_e   sub;
    sub_e   nxt_sub;
    logic   ew_dem;
    logic   ped_dem;
    logic   ew_g_entry;
    tsel_t  nxt_sel;
    logic   wd_clr;
    logic   wd_en;
    logic   wd_expired;

    assign wd_clr = (sub == GAP);
    assign wd_en  = (sub == RUN) && (phase != FAULT);

    phase_watchdog #(
        .WDOG_LIMIT (WDOG_LIMIT),
        .WDOG_W     (WDOG_W)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );

    // Next phase/sub-state. done is only honoured in RUN, and it takes
    // precedence over a watchdog expiry landing in the same cycle.
    always_comb begin
        nxt_phase = phase;
        nxt_sub   = sub;
        if (phase == FAULT) begin
            nxt_sub = GAP;
        end else if (sub == GAP) begin
            nxt_sub = RUN;
        end else if (i_done_counter) begin
            nxt_sub = GAP;
            if ((phase == NS_G) && !ew_dem && !ped_dem) begin
                nxt_phase = NS_G;
            end else begin
                nxt_phase = phase_succ(phase);
            end
        end else if (wd_expired) begin
            nxt_phase = FAULT;
            nxt_sub   = GAP;
        end
    end

    // The only way into EW_G is from RED1, so this marks the EW_G GAP edge.
    assign ew_g_entry = (nxt_phase == EW_G) && (phase != EW_G);

    // Selects stay low in GAP so the counter restarts for the new phase.
    assign nxt_sel = (nxt_sub == RUN) ? phase_tsel(nxt_phase) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase           <= RED2;
            sub             <= GAP;
            o_short_counter <= 1'b0;
            o_long_counter  <= 1'b0;
            o_ns_light      <= L_RED;
            o_ew_light      <= L_RED;
            o_walk          <= 1'b0;
            o_walk_flash    <= 1'b0;
            o_fault         <= 1'b0;
            ew_dem          <= 1'b0;
            ped_dem         <= 1'b0;
        end else begin
            phase           <= nxt_phase;
            sub             <= nxt_sub;
            o_short_counter <= nxt_sel.short_sel;
            o_long_counter  <= nxt_sel.long_sel;
            o_ns_light      <= ns_lamp(nxt_phase);
            o_ew_light      <= ew_lamp(nxt_phase);
            o_walk          <= (nxt_phase == EW_G);
            o_fault         <= (nxt_phase == FAULT);
            // Registered walk & almost_done, cut off as soon as EW_G is left
            // so the warning never lingers into EW_Y.
            o_walk_flash    <= o_walk && i_almost_done && (nxt_phase == EW_G);
            // Clearing wins: a request coincident with EW_G entry is already
            // being served by that green.
            ew_dem          <= ew_g_entry ? 1'b0 : (ew_dem  | i_ew_sensor);
            ped_dem         <= ew_g_entry ? 1'b0 : (ped_dem | i_ped_req);
        end
    end

endmodule
